uart_sender: RTL and testbench

Byte transmit stage downstream of the `out` unit. It accepts committed output bytes over the `sender_valid`/`sender_ready`/`sender_in` handshake and buffers them in a small FIFO. It serializes them onto the board UART TX line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). Because of the FIFO, `out` can commit bursts of bytes without waiting for each frame to finish.

---
 rtl/uart_sender.sv | 132 +++++++++++++
 tb/tb_uart_sender.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sender.sv
// Byte transmit stage: a small FIFO that buffers committed bytes and
// serializes them as 8N1 UART frames on txd.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLK_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLK_PER_BIT cycles each
// STOP  | stop bit (high); chains straight into START if the FIFO holds more
module uart_sender #(
   parameter int CLK_PER_BIT = 868,
   parameter int DEPTH       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sender_valid,
   input  logic [7:0] sender_in,
   output logic       sender_ready,
   output logic       txd,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLK_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_d;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [7:0]    shift, shift_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [BW-1:0] baud, baud_d;
   logic          txd_d;
   logic          push, pop, bit_end;

   // Ready depends only on registered count, so a same-cycle pop never
   // opens a slot for a push offered at count == DEPTH.
   assign sender_ready = (count < FULL);
   assign push         = sender_valid && sender_ready;
   assign bit_end      = (baud == '0);
   assign busy         = (state != IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= sender_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && bit_idx == 3'd7) state_d = STOP;
         STOP: begin
            if (bit_end) begin
               if (count != '0) begin
                  pop     = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // txd is computed from the next-cycle state/shift so it can be registered.
   always_comb begin
      shift_d   = shift;
      bit_idx_d = bit_idx;
      baud_d    = (bit_end || state == IDLE) ? BAUD_MAX : baud - BW'(1);
      if (pop) begin
         shift_d   = mem[rptr];
         bit_idx_d = '0;
         baud_d    = BAUD_MAX;
      end else if (state == DATA && bit_end) begin
         shift_d   = {1'b0, shift[7:1]};
         bit_idx_d = bit_idx + 3'd1;
      end
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift   <= '0;
         bit_idx <= '0;
         baud    <= BAUD_MAX;
         txd     <= 1'b1;
      end else begin
         shift   <= shift_d;
         bit_idx <= bit_idx_d;
         baud    <= baud_d;
         txd     <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender at CLK_PER_BIT=4, DEPTH=4; a line
// decoder samples txd mid-bit and queues received bytes.
module tb_uart_sender;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sender_valid = 1'b0;
   logic [7:0] sender_in = 8'h00;
   logic       sender_ready, txd, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   uart_sender #(.CLK_PER_BIT(4), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .sender_valid(sender_valid), .sender_in(sender_in),
      .sender_ready(sender_ready), .txd(txd), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // line decoder: rx_cnt 0 is the first low cycle; bit i sampled at 4*(i+1)+2
   logic [7:0] rx_q[$];
   int         rx_start[$];
   int         rx_cnt = 0;
   bit         rx_on = 1'b0;
   logic [7:0] rx_sh = 8'h00;
   int         stop_err = 0;

   always @(negedge clk) begin
      if (reset) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (txd === 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
            rx_start.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2) rx_sh[(rx_cnt-6)/4] = txd;
         if (rx_cnt == 38) begin
            if (txd !== 1'b1) stop_err++;
            rx_q.push_back(rx_sh);
         end
         if (rx_cnt == 39) rx_on = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // returns one tick after the accepting edge, with sender_valid dropped
   task automatic send(input logic [7:0] b);
      int n;
      sender_valid = 1'b1;
      sender_in    = b;
      n = 0;
      while (!sender_ready && n < 100) begin
         step(1);
         n++;
      end
      if (n >= 100) check("send_timeout", n, 0);
      step(1);
      sender_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step(1);
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_start.delete();
   endtask

   int nacc;
   int first_drop;
   int acc_edge[8];
   logic r;

   initial begin
      // reset state
      step(2);
      check("rst_txd", txd, 1);
      check("rst_ready", sender_ready, 1);
      check("rst_busy", busy, 0);
      @(negedge clk) reset = 1'b0;
      step(1);

      // single byte 0xA5: send returns in cycle 0 (push edge 0)
      clear_rx();
      send(8'hA5);
      check("a5_c0_txd", txd, 1);
      check("a5_c0_busy", busy, 1);
      step(1);  check("a5_c1_start", txd, 0);
      step(3);  check("a5_c4_start", txd, 0);
      step(1);  check("a5_c5_bit0", txd, 1);
      step(4);  check("a5_c9_bit1", txd, 0);
      step(23); check("a5_c32_bit6", txd, 0);
      step(1);  check("a5_c33_bit7", txd, 1);
      step(4);  check("a5_c37_stop", txd, 1);
      step(3);  check("a5_c40_busy", busy, 1);
      step(1);  check("a5_c41_busy", busy, 0);
      check("a5_count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("a5_byte", rx_q[0], 8'hA5);

      // back-to-back frames
      clear_rx();
      send(8'h00);
      send(8'hFF);
      send(8'h55);
      wait_idle("b2b_idle", 200);
      check("b2b_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("b2b_byte0", rx_q[0], 8'h00);
         check("b2b_byte1", rx_q[1], 8'hFF);
         check("b2b_byte2", rx_q[2], 8'h55);
         check("b2b_gap01", rx_start[1] - rx_start[0], 40);
         check("b2b_gap12", rx_start[2] - rx_start[1], 40);
      end

      // full / backpressure: hold valid with incrementing data
      clear_rx();
      nacc = 0;
      first_drop = -1;
      sender_valid = 1'b1;
      sender_in = 8'h20;
      for (int c = 0; c < 400 && nacc < 8; c++) begin
         r = sender_ready;
         if (!r && first_drop < 0) begin
            first_drop = nacc;
            check("full_busy", busy, 1);
         end
         step(1);
         if (r) begin
            acc_edge[nacc] = cyc;
            nacc++;
            sender_in = sender_in + 8'd1;
         end
      end
      sender_valid = 1'b0;
      check("full_accepts", nacc, 8);
      check("full_first_drop", first_drop, 5);
      check("full_reopen", acc_edge[5] - acc_edge[0], 42);
      check("full_per_frame", acc_edge[6] - acc_edge[5], 40);
      wait_idle("full_idle", 500);
      check("full_rx_count", rx_q.size(), 8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++)
         check($sformatf("full_byte%0d", i), rx_q[i], 8'h20 + 8'(i));

      // push on the STOP->START pop edge with count == 1
      clear_rx();
      send(8'hC3);           // push edge k
      sender_valid = 1'b1;
      sender_in = 8'h5A;
      step(1);               // push edge k+1 (pop of C3 same edge)
      sender_valid = 1'b0;
      step(39);
      sender_valid = 1'b1;
      sender_in = 8'h96;
      step(1);               // push edge k+41 = pop of 5A
      sender_valid = 1'b0;
      check("pp_start_y", txd, 0);
      wait_idle("pp_idle", 200);
      check("pp_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("pp_byte0", rx_q[0], 8'hC3);
         check("pp_byte1", rx_q[1], 8'h5A);
         check("pp_byte2", rx_q[2], 8'h96);
         check("pp_gap", rx_start[2] - rx_start[1], 40);
      end

      // pointer wrap with intermittent valid
      clear_rx();
      for (int i = 0; i < 11; i++) begin
         step(i % 3);
         send(8'h10 + 8'(i));
      end
      wait_idle("wrap_idle", 600);
      check("wrap_count", rx_q.size(), 11);
      for (int i = 0; i < 11 && i < rx_q.size(); i++)
         check($sformatf("wrap_byte%0d", i), rx_q[i], 8'h10 + 8'(i));

      // reset during DATA bit 3 of 0x3C with two bytes queued
      clear_rx();
      send(8'h3C);
      send(8'h11);
      send(8'h22);           // now in cycle k+2
      step(16);              // cycle k+18, inside bit 3
      check("mid_bit3", txd, 1);
      check("mid_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_txd", txd, 1);
      check("mid_rst_ready", sender_ready, 1);
      check("mid_rst_busy", busy, 0);
      step(2);
      @(negedge clk) reset = 1'b0;
      clear_rx();
      step(1);
      send(8'h81);
      wait_idle("mid_idle", 200);
      step(50);
      check("mid_busy_after", busy, 0);
      check("mid_count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("mid_byte", rx_q[0], 8'h81);

      check("stop_bits", stop_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
